// File: rtl/morse_key_decoder.sv
// Morse key decoder: conditions a raw key, times presses/gaps on a 100 ms tick, emits dot/dash elements and symbols.
// Optional build macro MORSE_DEBOUNCE_EN adds a 16-cycle debounce after the synchronizer.
module morse_key_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_100ms,
    input  logic       key_in,
    output logic       sym_valid,
    output logic [4:0] sym_bits,
    output logic [2:0] sym_len,
    output logic       elem_pulse,
    output logic       elem_dash,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_r;
    logic       sync1_r;
    logic       sync2_r;
    logic       key_s;
    logic       key_d_r;
    logic [4:0] press_cnt_r;
    logic [1:0] gap_cnt_r;
    logic [4:0] acc_r;
    logic [2:0] elem_cnt_r;
    logic       rise_s;
    logic       fall_s;
    logic [4:0] press_next_s;
    logic [1:0] gap_next_s;

    // Two-flop synchronizer for the asynchronous key level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= key_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    logic [3:0] db_cnt_r;
    logic       key_db_r;

    // Debounce: accept a new level only after 16 consecutive cycles at that level
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_r <= 4'd0;
            key_db_r <= 1'b0;
        end else if (sync2_r == key_db_r) begin
            db_cnt_r <= 4'd0;
        end else if (db_cnt_r == 4'd15) begin
            db_cnt_r <= 4'd0;
            key_db_r <= sync2_r;
        end else begin
            db_cnt_r <= db_cnt_r + 4'd1;
        end
    end

    assign key_s = key_db_r;
`else
    assign key_s = sync2_r;
`endif

    // Previous conditioned key level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            key_d_r <= 1'b0;
        end else begin
            key_d_r <= key_s;
        end
    end

    // Edge detect and next counter values; a tick coinciding with release still counts
    always_comb begin
        rise_s = key_s & ~key_d_r;
        fall_s = ~key_s & key_d_r;
        if (tick_100ms && (press_cnt_r != 5'd31)) begin
            press_next_s = press_cnt_r + 5'd1;
        end else begin
            press_next_s = press_cnt_r;
        end
        if (tick_100ms) begin
            gap_next_s = gap_cnt_r + 2'd1;
        end else begin
            gap_next_s = gap_cnt_r;
        end
    end

    // Decoder FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            press_cnt_r <= 5'd0;
            gap_cnt_r   <= 2'd0;
            acc_r       <= 5'd0;
            elem_cnt_r  <= 3'd0;
            sym_valid   <= 1'b0;
            sym_bits    <= 5'd0;
            sym_len     <= 3'd0;
            elem_pulse  <= 1'b0;
            elem_dash   <= 1'b0;
            err         <= 1'b0;
        end else begin
            sym_valid  <= 1'b0;
            elem_pulse <= 1'b0;
            err        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        press_cnt_r <= 5'd0;
                        state_r     <= PRESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS: begin
                    press_cnt_r <= press_next_s;
                    if (press_next_s >= 5'd20) begin
                        // Stuck key: drop the partial symbol, wait for release
                        err        <= 1'b1;
                        acc_r      <= 5'd0;
                        elem_cnt_r <= 3'd0;
                        state_r    <= fall_s ? IDLE : HOLD;
                    end else if (fall_s) begin
                        if (press_next_s == 5'd0) begin
                            state_r <= (elem_cnt_r == 3'd0) ? IDLE : GAP;
                        end else if (elem_cnt_r == 3'd5) begin
                            err        <= 1'b1;
                            acc_r      <= 5'd0;
                            elem_cnt_r <= 3'd0;
                            state_r    <= IDLE;
                        end else begin
                            elem_pulse         <= 1'b1;
                            elem_dash          <= (press_next_s >= 5'd3);
                            acc_r[elem_cnt_r]  <= (press_next_s >= 5'd3);
                            elem_cnt_r         <= elem_cnt_r + 3'd1;
                            gap_cnt_r          <= 2'd0;
                            state_r            <= GAP;
                        end
                    end else begin
                        state_r <= PRESS;
                    end
                end
                GAP: begin
                    gap_cnt_r <= gap_next_s;
                    if (gap_next_s == 2'd3) begin
                        // Symbol completion wins over a coincident press
                        sym_valid   <= 1'b1;
                        sym_bits    <= acc_r;
                        sym_len     <= elem_cnt_r;
                        acc_r       <= 5'd0;
                        elem_cnt_r  <= 3'd0;
                        press_cnt_r <= 5'd0;
                        state_r     <= rise_s ? PRESS : IDLE;
                    end else if (rise_s) begin
                        press_cnt_r <= 5'd0;
                        state_r     <= PRESS;
                    end else begin
                        state_r <= GAP;
                    end
                end
                HOLD: begin
                    if (!key_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all other ports are listed below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 tick_100ms  input  1  one-clk-wide pulse every 100 ms from the shared timebase.
REQ-005 key_in  input  1  raw Morse key level, 1 = pressed, asynchronous to clk.
REQ-006 sym_valid  output  1  one-clk pulse: completed symbol on sym_bits/sym_len.
REQ-007 sym_bits  output  5  element i at bit i, first element at bit 0; 0 = dot, 1 = dash; unused bits 0.
REQ-008 sym_len  output  3  number of elements, 1..5; held until next sym_valid.
REQ-009 elem_pulse  output  1  one-clk pulse per accepted element.
REQ-010 elem_dash  output  1  valid with elem_pulse: 1 = dash, 0 = dot.
REQ-011 err  output  1  one-clk pulse on overflow or stuck key.

Function
REQ-012 key_in SHALL pass through a 2-flop synchronizer; "key" below means the conditioned level.
REQ-013 FSM states SHALL be IDLE, PRESS, GAP, and HOLD.
REQ-014 IDLE -> PRESS on key rising edge; press counter cleared to 0.
REQ-015 PRESS: each tick_100ms increments a 5-bit saturating press counter.
REQ-016 Tick in same cycle as key falling edge SHALL count toward press duration.
REQ-017 Release with count 0 SHALL be discarded as noise: no element, return to prior context (IDLE if no elements held, else GAP with gap count kept).
REQ-018 Release with count 1..2 SHALL be a dot; count >= 3 SHALL be a dash.
REQ-019 Accepted element SHALL assert elem_pulse/elem_dash in the cycle after release is detected, append at index = element count, then enter GAP with gap counter 0.
REQ-020 GAP: each tick increments the gap counter; key rising edge before gap count 3 -> PRESS (same symbol).
REQ-021 Key rising edge coinciding with the 3rd gap tick SHALL give priority to symbol completion; the press starts a new symbol.
REQ-022 Gap count reaching 3 SHALL register sym_bits/sym_len and pulse sym_valid in the next cycle, clear the accumulator, and return to IDLE.
REQ-023 A 6th element SHALL pulse err, discard the accumulator, emit no sym_valid, and return to IDLE once the key is released.
REQ-024 Press count reaching 20 (2.0 s) SHALL pulse err, discard the accumulator, and enter HOLD.
REQ-025 HOLD SHALL ignore ticks and exit to IDLE on key release, producing no element.
REQ-026 All outputs SHALL be registered; sym_valid, elem_pulse, and err are never high for more than one cycle.

Reset
REQ-027 On rst at a clk edge: FSM = IDLE, counters = 0, accumulator = 0, synchronizer flops = 0.
REQ-028 On reset, all outputs = 0, including sym_bits and sym_len.
REQ-029 Reset mid-symbol or mid-press SHALL discard all partial data without a sym_valid or err pulse; reset has priority over every other event.

Configuration
REQ-030 Macro MORSE_DEBOUNCE_EN, defined: the synchronized key SHALL update only after 16 consecutive clk cycles at a new level; shorter glitches are ignored, adding 16 cycles of latency.
REQ-031 MORSE_DEBOUNCE_EN undefined: the synchronizer output SHALL be used directly (2-cycle latency); the port list is identical in both builds.

Verification
REQ-032 Press 2 ticks, release, idle 3 ticks -> elem_pulse with elem_dash = 0; sym_valid with sym_len = 1, sym_bits = 00000.
REQ-033 Sequence dot, dash, dash, gaps 1 tick, final gap 3 ticks ("W") -> sym_len = 3, sym_bits = 00110, single sym_valid.
REQ-034 Press spanning 0 ticks (released between ticks) -> no elem_pulse, no sym_valid, no err.
REQ-035 Six dots with 1-tick gaps -> err pulse on the 6th element; no sym_valid.
REQ-036 Hold key for 25 ticks -> err at the 20th tick; no element on release; next dot decodes normally as sym_len = 1.
REQ-037 rst asserted after 2 of 3 elements -> outputs 0; no sym_valid; next symbol decodes from element index 0.
